// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Owns the HI/LO architectural registers. MULT/MULTU use shift-add and
// DIV/DIVU use restoring shift-subtract, both on operand magnitudes; a final
// FIX cycle applies sign correction and writes HI/LO. Every result takes
// WIDTH+1 cycles from the start edge.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             rd_hilo,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   logic               is_div;     // latched op[1]
   logic               sign_a;     // dividend / multiplicand was negative
   logic               sign_b;     // divisor / multiplier was negative
   logic               div_zero;   // divisor was zero at launch
   logic [WIDTH-1:0]   a_raw;      // original dividend pattern for divide-by-zero
   logic [WIDTH-1:0]   operand;    // multiplicand or divisor magnitude
   logic [WIDTH:0]     work_hi;    // product high part / partial remainder
   logic [WIDTH-1:0]   work_lo;    // multiplier -> product low / dividend -> quotient
   logic [CW-1:0]      count;

   // Launch-time operand conditioning
   logic               signed_op;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   // Per-iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;

   // Sign-corrected results
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign busy  = (state != IDLE);
   // Combinational so the dependent instruction in EX is held until done.
   assign stall = busy & (start | rd_hilo | we_hi | we_lo);

   // Operand magnitudes and sign flags captured at launch
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      signed_op = ~op[0];
      a_neg     = signed_op & a[WIDTH-1];
      b_neg     = signed_op & b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
   end

   // One shift-add or shift-subtract step
   always_comb begin
      mul_sum   = work_hi + {1'b0, (work_lo[0] ? operand : {WIDTH{1'b0}})};
      div_shift = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, operand};
      div_ge    = (div_shift >= {1'b0, operand});
   end

   // Sign correction and result selection used by the FIX cycle
   always_comb begin
      prod     = {work_hi[WIDTH-1:0], work_lo};
      prod_fix = (sign_a ^ sign_b) ? -prod : prod;
      quo_fix  = (sign_a ^ sign_b) ? -work_lo : work_lo;
      rem_fix  = sign_a ? -work_hi[WIDTH-1:0] : work_hi[WIDTH-1:0];
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      res_lo   = prod_fix[WIDTH-1:0];
      if (is_div) begin
         if (div_zero) begin
            // Divide by zero is defined, not trapped: quotient all ones, remainder = dividend.
            res_hi = a_raw;
            res_lo = {WIDTH{1'b1}};
         end else begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
      end
   end

   // Control FSM, iteration datapath and HI/LO registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: all state, including the working accumulators, is reset so a mid-operation reset leaves nothing stale.
         state    <= IDLE;
         is_div   <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         div_zero <= 1'b0;
         a_raw    <= '0;
         operand  <= '0;
         work_hi  <= '0;
         work_lo  <= '0;
         count    <= '0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; every read sees the pre-edge value.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (we_hi) hi <= wdata;
               if (we_lo) lo <= wdata;
               if (start && !flush) begin
                  is_div   <= op[1];
                  sign_a   <= a_neg;
                  sign_b   <= b_neg;
                  div_zero <= (b == '0);
                  a_raw    <= a;
                  work_hi  <= '0;
                  count    <= '0;
                  if (op[1]) begin
                     work_lo <= a_mag;
                     operand <= b_mag;
                  end else begin
                     work_lo <= b_mag;
                     operand <= a_mag;
                  end
                  state <= RUN;
               end
            end

            RUN: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     if (div_ge) begin
                        work_hi <= div_diff;
                        work_lo <= {work_lo[WIDTH-2:0], 1'b1};
                     end else begin
                        work_hi <= div_shift;
                        work_lo <= {work_lo[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     work_hi <= {1'b0, mul_sum[WIDTH:1]};
                     work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                  end
                  count <= count + 1'b1;
                  if (count == CW'(WIDTH - 1)) state <= FIX;
               end
            end

            FIX: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected HI/LO values come from a
// behavioural arithmetic model, are queued at launch and compared on done.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             flush = 1'b0;
   logic             rd_hilo = 1'b0;
   logic             we_hi = 1'b0;
   logic             we_lo = 1'b0;
   logic [WIDTH-1:0] wdata = '0;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   int checks = 0;
   int passes = 0;
   logic [63:0] sb[$];

   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .rd_hilo(rd_hilo), .we_hi(we_hi), .we_lo(we_lo),
      .wdata(wdata), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   // Reference model: returns {hi, lo}
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint     sx, sy;
      int         ix, iy;
      logic [63:0] r;
      case (o)
         OP_MULT: begin
            sx = $signed(x);
            sy = $signed(y);
            r  = sx * sy;
         end
         OP_MULTU: r = {32'b0, x} * {32'b0, y};
         OP_DIV: begin
            if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin
               ix = $signed(x);
               iy = $signed(y);
               r  = {32'(ix % iy), 32'(ix / iy)};
            end
         end
         default: begin
            if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else r = {x % y, x / y};
         end
      endcase
      return r;
   endfunction

   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (push) sb.push_back(model(o, x, y));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic score_result(input string name);
      logic [63:0] exp;
      checks++;
      if (sb.size() == 0) begin
         $display("FAIL %s: done with empty scoreboard, got hi=%h lo=%h", name, hi, lo);
         return;
      end
      exp = sb.pop_front();
      if (hi !== exp[63:32]) $display("FAIL %s hi: got %h expected %h", name, hi, exp[63:32]);
      else passes++;
      checks++;
      if (lo !== exp[31:0]) $display("FAIL %s lo: got %h expected %h", name, lo, exp[31:0]);
      else passes++;
   endtask

   // n counts edges after the start edge, sampled on falling edges
   task automatic wait_done(input string name, input int n0, output int n, output int busy_cycles);
      n = n0;
      busy_cycles = 0;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) busy_cycles++;
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         $display("FAIL %s timeout: done=%b, expected 1 within 100 cycles", name, done);
      end else begin
         score_result(name);
      end
   endtask

   task automatic check_latency(input string name, input int n, input int exp_n);
      checks++;
      if (n !== exp_n) $display("FAIL %s latency: got %0d expected %0d", name, n, exp_n);
      else passes++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({hi, lo} !== 64'd0) $display("FAIL reset hilo: got %h expected 0", {hi, lo});
      else passes++;
      checks++;
      if ({busy, done, stall} !== 3'b000) $display("FAIL reset flags: got %b expected 000", {busy, done, stall});
      else passes++;
   endtask

   task automatic test_multu_max();
      int n, bc;
      launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_done("multu_max", 0, n, bc);
      check_latency("multu_max", n, 33);
      checks++;
      if (bc !== 33) $display("FAIL multu_max busy cycles: got %0d expected 33", bc);
      else passes++;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) $display("FAIL multu_max done width: got %b expected 0", done);
      else passes++;
   endtask

   task automatic test_signed();
      int n, bc;
      launch(OP_MULT, 32'hFFFF_FFF9, 32'd6, 1'b1);
      wait_done("mult_neg", 0, n, bc);
      launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done("div_neg", 0, n, bc);
      check_latency("div_neg", n, 33);
   endtask

   task automatic test_div_corner();
      int n, bc;
      launch(OP_DIVU, 32'd100, 32'd0, 1'b1);
      wait_done("divu_zero", 0, n, bc);
      launch(OP_DIV, 32'hFFFF_FFF9, 32'd0, 1'b1);
      wait_done("div_zero", 0, n, bc);
      launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done("div_ovf", 0, n, bc);
      launch(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
      wait_done("mult_min", 0, n, bc);
   endtask

   task automatic test_stall();
      int n;
      launch(OP_DIVU, 32'd1000, 32'd7, 1'b1);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         if (n == 5) rd_hilo = 1'b1;
         #1;
         checks++;
         if (stall !== (n >= 5)) $display("FAIL stall cycle %0d: got %b expected %b", n, stall, (n >= 5));
         else passes++;
         @(negedge clk);
         n++;
      end
      #1;
      checks++;
      if (done !== 1'b1 || stall !== 1'b0) $display("FAIL stall at done: got done=%b stall=%b expected 1 0", done, stall);
      else passes++;
      check_latency("stall", n, 33);
      if (done === 1'b1) score_result("divu_1000_7");
      rd_hilo = 1'b0;
   endtask

   task automatic test_flush();
      int n, bc;
      bit saw_done;
      saw_done = 1'b0;
      launch(OP_MULTU, 32'd3, 32'd5, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) $display("FAIL flush busy: got %b expected 0", busy);
      else passes++;
      checks++;
      if (hi !== 32'd6 || lo !== 32'd142) $display("FAIL flush hilo kept: got %h/%h expected 6/142", hi, lo);
      else passes++;
      repeat (30) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done) $display("FAIL flush done: got a done pulse, expected none");
      else passes++;
      // Flush in IDLE swallows a same-cycle start.
      start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++;
      if (busy !== 1'b0) $display("FAIL idle flush busy: got %b expected 0", busy);
      else passes++;
      launch(OP_MULTU, 32'd3, 32'd5, 1'b1);
      wait_done("after_flush", 0, n, bc);
   endtask

   task automatic test_mthi();
      int n, bc;
      @(negedge clk);
      we_hi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      we_hi = 1'b0;
      checks++;
      if (hi !== 32'h1234 || lo !== 32'd15) $display("FAIL mthi: got %h/%h expected 1234/f", hi, lo);
      else passes++;
      // MTLO together with a start: write lands, then FIX overwrites it.
      we_lo = 1'b1; wdata = 32'hABCD; start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
      sb.push_back(model(OP_MULTU, 32'd2, 32'd3));
      @(negedge clk);
      we_lo = 1'b0; start = 1'b0;
      checks++;
      if (lo !== 32'hABCD || busy !== 1'b1) $display("FAIL mtlo+start: got lo=%h busy=%b expected abcd 1", lo, busy);
      else passes++;
      // MTHI while busy is stalled and ignored.
      we_hi = 1'b1; wdata = 32'hDEAD;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL mthi busy stall: got %b expected 1", stall);
      else passes++;
      @(negedge clk);
      we_hi = 1'b0;
      wait_done("mtlo_start", 1, n, bc);
      check_latency("mtlo_start", n, 33);
   endtask

   task automatic test_start_ignored();
      int n, bc;
      launch(OP_MULT, 32'd5, 32'hFFFF_FFF9, 1'b1);
      start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL start busy stall: got %b expected 1", stall);
      else passes++;
      @(negedge clk);
      start = 1'b0;
      wait_done("start_ignored", 1, n, bc);
      check_latency("start_ignored", n, 33);
   endtask

   task automatic test_reset_mid();
      launch(OP_MULT, 32'h0001_2345, 32'h0000_0777, 1'b1);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({hi, lo} !== 64'd0) $display("FAIL reset_mid hilo: got %h expected 0", {hi, lo});
      else passes++;
      checks++;
      if ({busy, done, stall} !== 3'b000) $display("FAIL reset_mid flags: got %b expected 000", {busy, done, stall});
      else passes++;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_mid busy after release: got %b expected 0", busy);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int n, bc;
      logic [1:0] o;
      logic [31:0] x, y;
      for (int i = 0; i < 8; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = (i % 2 == 1) ? 32'($urandom) : 32'($urandom_range(1, 50));
         if (i % 4 == 0) x = -x;
         launch(o, x, y, 1'b1);
         wait_done("random", 0, n, bc);
         check_latency("random", n, 33);
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signed();
      test_div_corner();
      test_stall();
      test_flush();
      test_mthi();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
